// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic inter-stage pipeline register. Carries a control bundle and a data
// bundle between two pipeline stages under a valid/ready handshake.
//
//   SKID = 1 : two entries (main + skid). in_ready is taken from a flop, so no
//              combinational path runs from out_ready back to in_ready.
//   SKID = 0 : single entry. in_ready = ~out_valid | out_ready.
//
// A flush inserts a bubble: every stored entry is invalidated and its control
// bundle is cleared. Data is cleared too when CLR_DATA = 1. A saturating
// counter records the cycles in which the output is valid but not accepted.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   flush      synchronous clear of all stored entries
//   in_valid   upstream holds a valid instruction
//   in_ready   this stage accepts the input this cycle
//   in_ctrl    upstream control bundle  [CTRL_W]
//   in_data    upstream data bundle     [DATA_W]
//   out_valid  output entry valid
//   out_ready  downstream accepts the output this cycle
//   out_ctrl   registered control bundle, zero whenever out_valid = 0
//   out_data   registered data bundle
//   stall_cnt  saturating count of cycles with out_valid & ~out_ready
//   stall_clr  synchronous clear of stall_cnt (wins over an increment)
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int unsigned CTRL_W   = 8,
    parameter int unsigned DATA_W   = 101,
    parameter int unsigned SKID     = 1,
    parameter int unsigned CLR_DATA = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    // Occupancy of the two-entry variant. ONE means only the main register
    // holds an entry; FULL means the skid entry holds the younger one.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // Main (output) register, shared by both variants.
    logic              out_valid_q;
    logic [CTRL_W-1:0] out_ctrl_q;
    logic [DATA_W-1:0] out_data_q;

    // Stall counter.
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;

    generate
        if (SKID != 0) begin : g_skid
            state_e            state_q;
            logic              in_ready_q;
            logic [CTRL_W-1:0] skid_ctrl_q;
            logic [DATA_W-1:0] skid_data_q;
            logic              fire_in;

            // in_ready_q is 1 exactly when the skid entry is free, i.e. in
            // EMPTY and ONE, so accepting never depends on out_ready.
            assign fire_in  = in_valid & in_ready_q;
            assign in_ready = in_ready_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_ctrl_q  <= '0;
                    out_data_q  <= '0;
                    skid_ctrl_q <= '0;
                    skid_data_q <= '0;
                end else if (flush) begin
                    // Input presented this cycle is dropped along with the
                    // stored entries.
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_ctrl_q  <= '0;
                    skid_ctrl_q <= '0;
                    if (CLR_DATA != 0) begin
                        out_data_q  <= '0;
                        skid_data_q <= '0;
                    end
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            if (fire_in) begin
                                out_valid_q <= 1'b1;
                                out_ctrl_q  <= in_ctrl;
                                out_data_q  <= in_data;
                                state_q     <= ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (fire_in && out_ready) begin
                                out_ctrl_q <= in_ctrl;
                                out_data_q <= in_data;
                            end else if (fire_in) begin
                                // Downstream stalled: park the younger entry
                                // and close the input for the next cycle.
                                skid_ctrl_q <= in_ctrl;
                                skid_data_q <= in_data;
                                in_ready_q  <= 1'b0;
                                state_q     <= ST_FULL;
                            end else if (out_ready) begin
                                out_valid_q <= 1'b0;
                                out_ctrl_q  <= '0;
                                state_q     <= ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            if (out_ready) begin
                                out_ctrl_q  <= skid_ctrl_q;
                                out_data_q  <= skid_data_q;
                                skid_ctrl_q <= '0;
                                in_ready_q  <= 1'b1;
                                state_q     <= ST_ONE;
                            end
                        end
                        default: begin
                            state_q     <= ST_EMPTY;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_ctrl_q  <= '0;
                        end
                    endcase
                end
            end
        end else begin : g_single
            logic fire_in;
            logic fire_out;

            assign in_ready = ~out_valid_q | out_ready;
            assign fire_in  = in_valid & in_ready;
            assign fire_out = out_valid_q & out_ready;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_valid_q <= 1'b0;
                    out_ctrl_q  <= '0;
                    out_data_q  <= '0;
                end else if (flush) begin
                    out_valid_q <= 1'b0;
                    out_ctrl_q  <= '0;
                    if (CLR_DATA != 0) begin
                        out_data_q <= '0;
                    end
                end else if (fire_in) begin
                    out_valid_q <= 1'b1;
                    out_ctrl_q  <= in_ctrl;
                    out_data_q  <= in_data;
                end else if (fire_out) begin
                    out_valid_q <= 1'b0;
                    out_ctrl_q  <= '0;
                end
            end
        end
    endgenerate

    // Stall counter: clear beats increment; holds at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr) begin
            stall_cnt_d = '0;
        end else if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ctrl  = out_ctrl_q;
    assign out_data  = out_data_q;
    assign stall_cnt = stall_cnt_q;

endmodule
